// File: rtl/reg_decode_unit.sv
// Register file, immediate decode and load-use scoreboard; operands/imm/stall are combinational, writes on clk.
// No handshake: a busy source or destination raises stall, and the issuer holds inst until it drops.
module reg_decode_unit #(
  parameter int          XLEN     = 32,
  parameter int          NREG     = 32,
  parameter int          SP_IDX   = 31,
  parameter logic [31:0] SP_RESET = 32'hFFFFFC00
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     inst,
  input  logic            issue_valid,
  input  logic            wb_en,
  input  logic            wb_load,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] imm,
  output logic            stall,
  output logic            illegal_reg,
  output logic [5:0]      loads_pending
);

  localparam int              RW      = $clog2(NREG);
  localparam logic [5:0]      NREG_L  = 6'(NREG);
  localparam logic [XLEN-1:0] SP_INIT = XLEN'(SP_RESET);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic [XLEN-1:0] rf [NREG];
  logic [NREG-1:0] busy, busy_nxt;

  logic [6:0]    opcode;
  logic [4:0]    rs1, rs2, rd;
  logic [RW-1:0] rs1_i, rs2_i, rd_i, wb_i;
  logic          use_rs1, use_rs2, use_rd;
  logic          rs1_ok, rs2_ok, rd_ok, wb_ok;
  logic          wr_en, clr_req, clr_en, set_en;
  logic          rs1_busy, rs2_busy, rd_busy;
  logic [31:0]   imm32;
  logic          unused_funct3;

  assign opcode        = inst[6:0];
  assign rd            = inst[11:7];
  assign rs1           = inst[19:15];
  assign rs2           = inst[24:20];
  assign unused_funct3 = ^inst[14:12];

  assign rs1_ok = ({1'b0, rs1} < NREG_L);
  assign rs2_ok = ({1'b0, rs2} < NREG_L);
  assign rd_ok  = ({1'b0, rd} < NREG_L);
  assign wb_ok  = ({1'b0, wb_rd} < NREG_L);
  assign rs1_i  = rs1[RW-1:0];
  assign rs2_i  = rs2[RW-1:0];
  assign rd_i   = rd[RW-1:0];
  assign wb_i   = wb_rd[RW-1:0];

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    case (opcode)
      OP_R: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
      end
      OP_IMM, OP_LOAD, OP_JALR: begin
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
      end
      OP_STORE, OP_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_LUI, OP_AUIPC, OP_JAL: use_rd = 1'b1;
      default: ;
    endcase
  end

  // Write-first bypass: a same-cycle write-back is visible on the operand ports.
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (use_rs1 && rs1_ok && rs1 != 5'd0)
      rs1_data = (wb_en && wb_rd == rs1) ? wb_data : rf[rs1_i];
    if (use_rs2 && rs2_ok && rs2 != 5'd0)
      rs2_data = (wb_en && wb_rd == rs2) ? wb_data : rf[rs2_i];
  end

  always_comb begin
    imm32 = '0;
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR: imm32 = {{20{inst[31]}}, inst[31:20]};
      OP_STORE:  imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OP_BRANCH: imm32 = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      OP_LUI, OP_AUIPC: imm32 = {inst[31:12], 12'b0};
      OP_JAL:    imm32 = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      default: ;
    endcase
  end

  assign imm = XLEN'($signed(imm32));

  assign illegal_reg = issue_valid &&
                       ((use_rs1 && !rs1_ok) || (use_rs2 && !rs2_ok) || (use_rd && !rd_ok));

  // A load retiring into the blocking register this cycle releases the hazard immediately.
  assign clr_req  = wb_en && wb_load;
  assign rs1_busy = use_rs1 && rs1_ok && busy[rs1_i] && !(clr_req && wb_rd == rs1);
  assign rs2_busy = use_rs2 && rs2_ok && busy[rs2_i] && !(clr_req && wb_rd == rs2);
  assign rd_busy  = use_rd  && rd_ok  && busy[rd_i]  && !(clr_req && wb_rd == rd);
  assign stall    = issue_valid && !illegal_reg && (rs1_busy || rs2_busy || rd_busy);

  assign wr_en  = wb_en && wb_rd != 5'd0 && wb_ok;
  assign clr_en = clr_req && wb_ok && busy[wb_i];
  assign set_en = issue_valid && !stall && !illegal_reg && opcode == OP_LOAD && rd != 5'd0;

  always_comb begin
    busy_nxt = busy;
    if (clr_en) busy_nxt[wb_i] = 1'b0;
    if (set_en) busy_nxt[rd_i] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= (i == SP_IDX) ? SP_INIT : '0;
    end else if (wr_en) begin
      rf[wb_i] <= wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy          <= '0;
      loads_pending <= '0;
    end else begin
      busy <= busy_nxt;
      if (set_en && !clr_en && loads_pending != 6'd63)
        loads_pending <= loads_pending + 6'd1;
      else if (clr_en && !set_en && loads_pending != 6'd0)
        loads_pending <= loads_pending - 6'd1;
    end
  end

endmodule

// File: tb/tb_reg_decode_unit.sv
// Scoreboarded bench for reg_decode_unit: a 32-register instance plus a 16-register one sharing stimulus.
module tb_reg_decode_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst = '0;
  logic        issue_valid = 1'b0;
  logic        wb_en = 1'b0;
  logic        wb_load = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;

  logic [31:0] rs1_data, rs2_data, imm;
  logic        stall, illegal_reg;
  logic [5:0]  loads_pending;
  logic [31:0] rs1_16, rs2_16, imm_16;
  logic        stall_16, illegal_16;
  logic [5:0]  lp_16;

  always #5 clk = ~clk;

  reg_decode_unit dut (
    .clk(clk), .rst(rst), .inst(inst), .issue_valid(issue_valid),
    .wb_en(wb_en), .wb_load(wb_load), .wb_rd(wb_rd), .wb_data(wb_data),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .stall(stall),
    .illegal_reg(illegal_reg), .loads_pending(loads_pending)
  );

  reg_decode_unit #(.NREG(16), .SP_IDX(15)) dut16 (
    .clk(clk), .rst(rst), .inst(inst), .issue_valid(issue_valid),
    .wb_en(wb_en), .wb_load(wb_load), .wb_rd(wb_rd), .wb_data(wb_data),
    .rs1_data(rs1_16), .rs2_data(rs2_16), .imm(imm_16), .stall(stall_16),
    .illegal_reg(illegal_16), .loads_pending(lp_16)
  );

  typedef struct {
    string       tag;
    logic [31:0] rs1, rs2, imm;
    logic        stall, ill;
    logic [5:0]  lp;
    bit          do16;
    logic        ill16, stall16;
    logic [5:0]  lp16;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m [32];
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input string t, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] im, input logic st, input logic il,
                              input logic [5:0] lp);
    exp_t e;
    e.tag = t; e.rs1 = a; e.rs2 = b; e.imm = im; e.stall = st; e.ill = il; e.lp = lp;
    e.do16 = 1'b0; e.ill16 = 1'b0; e.stall16 = 1'b0; e.lp16 = '0;
    return e;
  endfunction

  function automatic exp_t with16(input exp_t e, input logic il, input logic st, input logic [5:0] lp);
    exp_t r = e;
    r.do16 = 1'b1; r.ill16 = il; r.stall16 = st; r.lp16 = lp;
    return r;
  endfunction

  task automatic chk_now(input exp_t e);
    exp_t c;
    sb.push_back(e);
    #1;
    c = sb.pop_front();
    check({c.tag, ".rs1"},   rs1_data, c.rs1);
    check({c.tag, ".rs2"},   rs2_data, c.rs2);
    check({c.tag, ".imm"},   imm, c.imm);
    check({c.tag, ".stall"}, 32'(stall), 32'(c.stall));
    check({c.tag, ".ill"},   32'(illegal_reg), 32'(c.ill));
    check({c.tag, ".lp"},    32'(loads_pending), 32'(c.lp));
    if (c.do16) begin
      check({c.tag, ".ill16"},   32'(illegal_16), 32'(c.ill16));
      check({c.tag, ".stall16"}, 32'(stall_16), 32'(c.stall16));
      check({c.tag, ".lp16"},    32'(lp_16), 32'(c.lp16));
    end
  endtask

  // One cycle of stimulus, checked before the next rising edge; the model takes the write.
  task automatic cyc(input logic [31:0] i, input logic iv, input logic we, input logic wl,
                     input logic [4:0] wr, input logic [31:0] wd, input exp_t e);
    @(negedge clk);
    inst = i; issue_valid = iv; wb_en = we; wb_load = wl; wb_rd = wr; wb_data = wd;
    chk_now(e);
    if (we && wr != 5'd0) m[wr] = wd;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 32; k++) m[k] = '0;
    m[31] = 32'hFFFFFC00;
  endtask

  function automatic logic [31:0] r_add(input logic [4:0] d, input logic [4:0] a, input logic [4:0] b);
    return {7'b0, b, a, 3'b000, d, 7'b0110011};
  endfunction

  initial begin
    logic [4:0]  ra, rb;
    logic [31:0] d;
    model_reset();

    cyc(r_add(5'd1, 5'd31, 5'd5), 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,
        mk("rst_read", 32'hFFFFFC00, 32'h0, 32'h0, 1'b0, 1'b0, 6'd0));
    rst = 1'b0;
    cyc(r_add(5'd1, 5'd0, 5'd0), 1'b1, 1'b1, 1'b0, 5'd0, 32'h1234,
        mk("x0_wb", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 6'd0));
    cyc(r_add(5'd1, 5'd0, 5'd0), 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,
        mk("x0_after", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 6'd0));
    cyc(r_add(5'd1, 5'd3, 5'd0), 1'b1, 1'b1, 1'b0, 5'd3, 32'hDEADBEEF,
        mk("bypass", 32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 1'b0, 6'd0));
    cyc(r_add(5'd1, 5'd3, 5'd0), 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,
        mk("x3_read", 32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 1'b0, 6'd0));

    cyc(32'hFE000EE3, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,
        mk("imm_b", 32'h0, 32'h0, 32'hFFFFFFFC, 1'b0, 1'b0, 6'd0));
    cyc(32'hABCDE137, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,
        mk("imm_u", 32'h0, 32'h0, 32'hABCDE000, 1'b0, 1'b0, 6'd0));
    cyc(32'hFFF18093, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,
        mk("imm_i", 32'hDEADBEEF, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0, 6'd0));
    cyc(32'h003FA423, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,
        mk("imm_s", 32'hFFFFFC00, 32'hDEADBEEF, 32'h8, 1'b0, 1'b0, 6'd0));
    cyc(32'hFFFFF06F, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,
        mk("imm_j", 32'h0, 32'h0, 32'hFFFFFFFE, 1'b0, 1'b0, 6'd0));

    for (int n = 0; n < 16; n++) begin
      ra = 5'($urandom_range(1, 31));
      d  = $urandom;
      cyc(32'h0, 1'b0, 1'b1, 1'b0, ra, d, mk("rnd_wr", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 6'd0));
    end
    for (int n = 0; n < 12; n++) begin
      ra = 5'($urandom_range(0, 31));
      rb = 5'($urandom_range(0, 31));
      cyc(r_add(5'd1, ra, rb), 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,
          with16(mk("rnd_rd", m[ra], m[rb], 32'h0, 1'b0, 1'b0, 6'd0),
                 (ra >= 5'd16) || (rb >= 5'd16), 1'b0, 6'd0));
    end

    // Load-use hazard on x7, released by the retiring load in the same cycle.
    cyc(32'h00012383, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,
        mk("lw_x7", m[2], 32'h0, 32'h0, 1'b0, 1'b0, 6'd0));
    cyc(32'h00138433, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,
        mk("use_stall", m[7], m[1], 32'h0, 1'b1, 1'b0, 6'd1));
    cyc(32'h00138433, 1'b1, 1'b1, 1'b1, 5'd7, 32'hCAFEF00D,
        mk("use_release", 32'hCAFEF00D, m[1], 32'h0, 1'b0, 1'b0, 6'd1));
    cyc(32'h0, 1'b0, 1'b1, 1'b1, 5'd9, 32'h55,
        mk("ld_not_busy", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 6'd0));
    cyc(r_add(5'd1, 5'd7, 5'd9), 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,
        mk("post_load", 32'hCAFEF00D, 32'h55, 32'h0, 1'b0, 1'b0, 6'd0));

    // x20 is legal for the 32-register instance only.
    cyc(32'h00208A33, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,
        with16(mk("x20_add", m[1], m[2], 32'h0, 1'b0, 1'b0, 6'd0), 1'b1, 1'b0, 6'd0));
    cyc(32'h0000AA03, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,
        with16(mk("x20_lw", m[1], 32'h0, 32'h0, 1'b0, 1'b0, 6'd0), 1'b1, 1'b0, 6'd0));
    cyc(32'h0, 1'b0, 1'b1, 1'b1, 5'd20, 32'h77,
        with16(mk("x20_ret", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 6'd1), 1'b0, 1'b0, 6'd0));
    cyc(32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,
        with16(mk("x20_done", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 6'd0), 1'b0, 1'b0, 6'd0));

    // Two loads in flight, then reset pulsed between edges.
    cyc(32'h00002503, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,
        mk("lw_x10", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 6'd0));
    cyc(32'h00402583, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,
        mk("lw_x11", 32'h0, 32'h0, 32'h4, 1'b0, 1'b0, 6'd1));
    cyc(32'h00B50633, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,
        mk("pre_rst", m[10], m[11], 32'h0, 1'b1, 1'b0, 6'd2));
    rst = 1'b1;
    model_reset();
    chk_now(mk("in_rst", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 6'd0));
    rst = 1'b0;
    chk_now(mk("post_rst", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 6'd0));
    cyc(r_add(5'd1, 5'd31, 5'd10), 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,
        mk("sp_again", 32'hFFFFFC00, 32'h0, 32'h0, 1'b0, 1'b0, 6'd0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
